// File: rtl/servo_move_queue_if.sv
// APB3 slave bus bundle for the servo move queue.
interface servo_move_queue_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/servo_move_queue.sv
// Servo move queue: APB3-loaded FIFO of (direction, periods) entries replayed as
// SET_PW_* strobes, each entry lasting a number of servo period_tick pulses.
//
// state | meaning
// IDLE  | no entry executing; head is popped when queue non-empty and not paused
// RUN   | entry executing; remain counts down on each period_tick
module servo_move_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    servo_move_queue_if.slave apb,
    input  logic              period_tick,
    output logic              cmd_forward,
    output logic              cmd_reverse,
    output logic              cmd_neutral,
    output logic              busy,
    output logic              irq_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;
    typedef struct packed {
        logic [1:0]       dir;
        logic [CNT_W-1:0] periods;
    } entry_t;

    entry_t           fifo_mem_q [DEPTH];
    entry_t           fifo_mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic             pause_q, pause_d, overflow_q, overflow_d, bad_cmd_q, bad_cmd_d;
    logic             fwd_q, fwd_d, rev_q, rev_d, neu_q, neu_d;
    logic             irq_q, irq_d, busy_q, busy_d;
    logic [31:0]      prdata_q, prdata_d;

    logic       wr_access, rd_setup, push_req, push_ok, push_rej, bad_dir;
    logic       ctrl_wr, flush, empty, full, ending, pop;
    logic [3:0] addr;
    entry_t     head;
    logic       unused_bits;

    assign addr      = apb.PADDR[3:0];
    assign wr_access = apb.PSEL & apb.PWRITE & apb.PENABLE;
    assign rd_setup  = apb.PSEL & ~apb.PWRITE & ~apb.PENABLE;
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_L);
    assign bad_dir   = (apb.PWDATA[CNT_W+1:CNT_W] == 2'b11);
    assign push_req  = wr_access && (addr == 4'h0);
    assign push_rej  = push_req && (full || bad_dir);
    assign push_ok   = push_req && !push_rej;
    assign ctrl_wr   = wr_access && (addr == 4'h8);
    assign flush     = ctrl_wr && apb.PWDATA[0];
    assign head      = fifo_mem_q[rd_ptr_q];
    assign ending    = (state_q == RUN) && period_tick && (remain_q == CNT_W'(1));
    // Pause only gates pops, so a running entry always finishes its periods.
    assign pop       = !flush && !empty && !pause_q && ((state_q == IDLE) || ending);

    assign unused_bits = ^{apb.PADDR[31:4], apb.PWDATA[31:CNT_W+2]};

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        state_d    = state_q;
        remain_d   = remain_q;
        pause_d    = pause_q;
        overflow_d = overflow_q;
        bad_cmd_d  = bad_cmd_q;
        prdata_d   = prdata_q;
        fwd_d      = 1'b0;
        rev_d      = 1'b0;
        neu_d      = 1'b0;
        irq_d      = 1'b0;

        if (push_ok) begin
            fifo_mem_d[wr_ptr_q] = entry_t'(apb.PWDATA[CNT_W+1:0]);
            wr_ptr_d             = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + LW'(push_ok) - LW'(pop);

        if (push_rej && full)    overflow_d = 1'b1;
        if (push_rej && bad_dir) bad_cmd_d  = 1'b1;
        if (ctrl_wr) begin
            pause_d = apb.PWDATA[1];
            if (apb.PWDATA[2]) begin
                overflow_d = 1'b0;
                bad_cmd_d  = 1'b0;
            end
        end

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            remain_d = '0;
            if (state_q == RUN) begin
                neu_d   = 1'b1;
                state_d = IDLE;
            end
        end else if (pop && (head.periods != '0)) begin
            remain_d = head.periods;
            state_d  = RUN;
            case (head.dir)
                2'b01:   fwd_d = 1'b1;
                2'b10:   rev_d = 1'b1;
                default: neu_d = 1'b1;
            endcase
        end else if (ending) begin
            // Also reached when the chained head is a zero-period entry.
            neu_d    = 1'b1;
            state_d  = IDLE;
            remain_d = '0;
            irq_d    = (count_d == '0);
        end else if ((state_q == RUN) && period_tick) begin
            remain_d = remain_q - CNT_W'(1);
        end

        busy_d = (state_d == RUN);

        if (rd_setup) begin
            case (addr)
                4'h4:    prdata_d = {16'h0, 8'(count_q), 2'b00, bad_cmd_q, overflow_q,
                                     pause_q, busy_q, full, empty};
                4'hC:    prdata_d = 32'(remain_q);
                default: prdata_d = 32'hFFFF_FFFF;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        fifo_mem_q <= fifo_mem_d;
        if (PRESET) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            remain_q   <= '0;
            pause_q    <= 1'b0;
            overflow_q <= 1'b0;
            bad_cmd_q  <= 1'b0;
            prdata_q   <= '0;
            fwd_q      <= 1'b0;
            rev_q      <= 1'b0;
            neu_q      <= 1'b0;
            irq_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            remain_q   <= remain_d;
            pause_q    <= pause_d;
            overflow_q <= overflow_d;
            bad_cmd_q  <= bad_cmd_d;
            prdata_q   <= prdata_d;
            fwd_q      <= fwd_d;
            rev_q      <= rev_d;
            neu_q      <= neu_d;
            irq_q      <= irq_d;
            busy_q     <= busy_d;
        end
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = push_rej;
    assign cmd_forward = fwd_q;
    assign cmd_reverse = rev_q;
    assign cmd_neutral = neu_q;
    assign busy        = busy_q;
    assign irq_done    = irq_q;
endmodule

// File: tb/tb_servo_move_queue.sv
// Bench for servo_move_queue: directed scenarios plus random APB/tick traffic,
// every cycle compared against a queue-based reference model.
module tb_servo_move_queue;
    localparam int DEPTH = 8;

    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    logic period_tick = 1'b0;
    logic cmd_forward, cmd_reverse, cmd_neutral, busy, irq_done;

    servo_move_queue_if apb_if();

    servo_move_queue #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .apb         (apb_if.slave),
        .period_tick (period_tick),
        .cmd_forward (cmd_forward),
        .cmd_reverse (cmd_reverse),
        .cmd_neutral (cmd_neutral),
        .busy        (busy),
        .irq_done    (irq_done)
    );

    always #5 PCLK = ~PCLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- tick source ----------------
    bit tick_en = 0;
    bit tick_rand = 0;
    int tick_cnt = 0;
    initial forever begin
        @(negedge PCLK);
        if (tick_rand) begin
            period_tick = ($urandom_range(0, 3) == 0);
        end else if (tick_en) begin
            tick_cnt++;
            period_tick = (tick_cnt % 20 == 0);
        end else begin
            tick_cnt = 0;
            period_tick = 1'b0;
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0]  dir;
        logic [15:0] per;
    } ent_t;

    ent_t        m_q[$];
    bit          m_run, m_pause, m_ovf, m_bad;
    logic [15:0] m_rem;
    bit          e_fwd, e_rev, e_neu, e_irq, e_busy;
    logic [31:0] e_prdata;
    int          ticks_busy = 0;
    bit          mw, mflush, mend, mpop, macc;
    ent_t        mh;

    function automatic logic [31:0] m_read(input logic [3:0] a);
        case (a)
            4'h4:    return {16'h0, 8'(m_q.size()), 2'b00, m_bad, m_ovf, m_pause, m_run,
                             m_q.size() == DEPTH, m_q.size() == 0};
            4'hC:    return {16'h0, m_rem};
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic m_slverr(input logic [31:0] a, input logic [31:0] d);
        return (a[3:0] == 4'h0) && (m_q.size() >= DEPTH || d[17:16] == 2'b11);
    endfunction

    always @(posedge PCLK) begin
        if (period_tick && busy) ticks_busy++;
        if (PRESET) begin
            m_q.delete();
            m_run = 0; m_pause = 0; m_ovf = 0; m_bad = 0; m_rem = 0;
            e_fwd = 0; e_rev = 0; e_neu = 0; e_irq = 0; e_busy = 0;
            e_prdata = 0;
        end else begin
            e_fwd = 0; e_rev = 0; e_neu = 0; e_irq = 0;
            if (apb_if.PSEL && !apb_if.PWRITE && !apb_if.PENABLE)
                e_prdata = m_read(apb_if.PADDR[3:0]);
            mw     = apb_if.PSEL && apb_if.PWRITE && apb_if.PENABLE;
            mflush = mw && apb_if.PADDR[3:0] == 4'h8 && apb_if.PWDATA[0];
            mend   = m_run && period_tick && m_rem == 1;
            mpop   = !mflush && (!m_run || mend) && m_q.size() > 0 && !m_pause;
            macc   = mw && apb_if.PADDR[3:0] == 4'h0 && m_q.size() < DEPTH
                     && apb_if.PWDATA[17:16] != 2'b11;
            if (mw && apb_if.PADDR[3:0] == 4'h0 && !macc) begin
                if (m_q.size() == DEPTH) m_ovf = 1;
                if (apb_if.PWDATA[17:16] == 2'b11) m_bad = 1;
            end
            if (mpop) mh = m_q.pop_front();
            if (macc) m_q.push_back(ent_t'(apb_if.PWDATA[17:0]));
            if (mflush) begin
                m_q.delete();
                m_rem = 0;
                if (m_run) begin e_neu = 1; m_run = 0; end
            end else if (mpop && mh.per != 0) begin
                m_rem = mh.per;
                m_run = 1;
                if (mh.dir == 2'b01) e_fwd = 1;
                else if (mh.dir == 2'b10) e_rev = 1;
                else e_neu = 1;
            end else if (mend) begin
                e_neu = 1; m_run = 0; m_rem = 0;
                e_irq = (m_q.size() == 0);
            end else if (m_run && period_tick) begin
                m_rem = m_rem - 1;
            end
            if (mw && apb_if.PADDR[3:0] == 4'h8) begin
                m_pause = apb_if.PWDATA[1];
                if (apb_if.PWDATA[2]) begin m_ovf = 0; m_bad = 0; end
            end
            e_busy = m_run;
        end
    end

    // ---------------- drivers ----------------
    int n_fwd = 0, n_rev = 0, n_neu = 0, n_irq = 0;
    int f0, r0, u0, i0, t0;

    task automatic cycle();
        @(posedge PCLK);
        @(negedge PCLK);
        check("cmd_forward", cmd_forward, e_fwd);
        check("cmd_reverse", cmd_reverse, e_rev);
        check("cmd_neutral", cmd_neutral, e_neu);
        check("busy", busy, e_busy);
        check("irq_done", irq_done, e_irq);
        n_fwd += int'(cmd_forward);
        n_rev += int'(cmd_reverse);
        n_neu += int'(cmd_neutral);
        n_irq += int'(irq_done);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic snap();
        f0 = n_fwd; r0 = n_rev; u0 = n_neu; i0 = n_irq; t0 = ticks_busy;
    endtask

    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d, output logic s);
        apb_if.PSEL = 1; apb_if.PWRITE = 1; apb_if.PENABLE = 0;
        apb_if.PADDR = a; apb_if.PWDATA = d;
        cycle();
        apb_if.PENABLE = 1;
        #1;
        check("pslverr", apb_if.PSLVERR, m_slverr(a, d));
        s = apb_if.PSLVERR;
        cycle();
        apb_if.PSEL = 0; apb_if.PENABLE = 0; apb_if.PWRITE = 0;
    endtask

    task automatic apb_rd(input logic [31:0] a, output logic [31:0] d);
        apb_if.PSEL = 1; apb_if.PWRITE = 0; apb_if.PENABLE = 0; apb_if.PADDR = a;
        cycle();
        apb_if.PENABLE = 1;
        #1;
        check("prdata", apb_if.PRDATA, e_prdata);
        d = apb_if.PRDATA;
        cycle();
        apb_if.PSEL = 0; apb_if.PENABLE = 0;
    endtask

    function automatic logic [31:0] mv(input logic [1:0] dir, input logic [15:0] per);
        return {14'h0, dir, per};
    endfunction

    logic        s;
    logic [31:0] rd;
    logic [1:0]  rdir;
    int          sel;

    initial begin
        apb_if.PSEL = 0; apb_if.PENABLE = 0; apb_if.PWRITE = 0;
        apb_if.PADDR = 0; apb_if.PWDATA = 0;
        PRESET = 1;
        run(3);
        check("rst_outputs", {cmd_forward, cmd_reverse, cmd_neutral, busy, irq_done}, 0);
        check("rst_prdata", apb_if.PRDATA, 0);
        PRESET = 0;
        run(2);
        apb_rd(32'h4, rd);
        check("rst_status", rd, 32'h1);

        // single fwd/3 entry
        snap();
        apb_wr(32'h0, mv(2'b01, 16'd3), s);
        tick_en = 1; run(100); tick_en = 0;
        check("t1_ticks_busy", ticks_busy - t0, 3);
        check("t1_fwd", n_fwd - f0, 1);
        check("t1_neutral", n_neu - u0, 1);
        check("t1_irq", n_irq - i0, 1);

        // chained fwd/2, rev/1, neutral/1
        snap();
        apb_wr(32'h0, mv(2'b01, 16'd2), s);
        apb_wr(32'h0, mv(2'b10, 16'd1), s);
        apb_wr(32'h0, mv(2'b00, 16'd1), s);
        tick_en = 1; run(100); tick_en = 0;
        check("t2_ticks_busy", ticks_busy - t0, 4);
        check("t2_fwd", n_fwd - f0, 1);
        check("t2_rev", n_rev - r0, 1);
        check("t2_neutral", n_neu - u0, 2);
        check("t2_irq", n_irq - i0, 1);

        // overflow and bad command
        apb_wr(32'h8, 32'h2, s);
        for (int i = 0; i < DEPTH; i++) apb_wr(32'h0, mv(2'b01, 16'd1), s);
        apb_wr(32'h0, mv(2'b01, 16'd1), s);
        check("t3_ovf_slverr", s, 1);
        apb_rd(32'h4, rd);
        check("t3_status_full", rd, 32'h81A);
        apb_wr(32'h8, 32'h3, s);
        apb_wr(32'h0, mv(2'b11, 16'd4), s);
        check("t3_bad_slverr", s, 1);
        apb_rd(32'h4, rd);
        check("t3_status_bad", rd, 32'h39);
        apb_wr(32'h8, 32'h4, s);
        apb_rd(32'h4, rd);
        check("t3_status_clr", rd, 32'h1);

        // zero-period entry is discarded
        snap();
        apb_wr(32'h0, mv(2'b10, 16'd0), s);
        apb_wr(32'h0, mv(2'b01, 16'd1), s);
        tick_en = 1; run(30); tick_en = 0;
        check("t4_rev", n_rev - r0, 0);
        check("t4_fwd", n_fwd - f0, 1);
        check("t4_irq", n_irq - i0, 1);

        // pause at entry boundary
        snap();
        apb_wr(32'h0, mv(2'b10, 16'd2), s);
        apb_wr(32'h0, mv(2'b01, 16'd2), s);
        apb_wr(32'h8, 32'h2, s);
        tick_en = 1; run(60);
        apb_rd(32'h4, rd);
        check("t5_status_paused", rd, 32'h108);
        check("t5_rev", n_rev - r0, 1);
        check("t5_neutral", n_neu - u0, 1);
        check("t5_irq", n_irq - i0, 0);
        check("t5_fwd_held", n_fwd - f0, 0);
        apb_wr(32'h8, 32'h0, s);
        run(3);
        check("t5_fwd_resumed", n_fwd - f0, 1);
        run(60); tick_en = 0;

        // flush during RUN
        snap();
        apb_wr(32'h0, mv(2'b01, 16'd8), s);
        tick_en = 1; run(65);
        apb_rd(32'hC, rd);
        check("t6_remain5", rd, 5);
        apb_wr(32'h8, 32'h1, s);
        tick_en = 0;
        check("t6_neutral", n_neu - u0, 1);
        check("t6_irq", n_irq - i0, 0);
        apb_rd(32'hC, rd);
        check("t6_remain0", rd, 0);
        apb_rd(32'h4, rd);
        check("t6_status", rd, 32'h1);
        apb_rd(32'h20, rd);
        check("t6_unmapped", rd, 32'hFFFF_FFFF);

        // reset mid-RUN
        apb_wr(32'h0, mv(2'b01, 16'd4), s);
        run(3);
        PRESET = 1;
        cycle();
        check("t7_rst_outputs", {cmd_forward, cmd_reverse, cmd_neutral, busy, irq_done}, 0);
        PRESET = 0;
        run(2);
        apb_rd(32'h4, rd);
        check("t7_status", rd, 32'h1);

        // random traffic
        tick_rand = 1;
        repeat (400) begin
            sel = $urandom_range(0, 9);
            if (sel <= 4) begin
                case ($urandom_range(0, 9))
                    0:       rdir = 2'b11;
                    1, 2:    rdir = 2'b00;
                    3, 4, 5: rdir = 2'b10;
                    default: rdir = 2'b01;
                endcase
                apb_wr(32'h0, mv(rdir, 16'($urandom_range(0, 3))), s);
            end else if (sel == 5) begin
                apb_wr(32'h8, {29'h0, 1'($urandom_range(0, 3) == 0),
                               1'($urandom_range(0, 2) == 0),
                               1'($urandom_range(0, 7) == 0)}, s);
            end else if (sel == 6) begin
                apb_rd(32'h4, rd);
            end else if (sel == 7) begin
                apb_rd(32'hC, rd);
            end else if (sel == 8) begin
                if ($urandom_range(0, 1) == 0) apb_rd($urandom(), rd);
                else apb_wr(32'h4, $urandom(), s);
            end else begin
                run($urandom_range(1, 6));
            end
        end
        tick_rand = 0;
        apb_wr(32'h8, 32'h0, s);
        tick_en = 1; run(200); tick_en = 0;
        run(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/servo_move_queue.md
# servo_move_queue

Upstream command sequencer for one tracking-servo axis. Firmware pushes timed move entries (direction + number of PWM periods) over APB3 into a FIFO; the block replays them by pulsing the servo's SET_PW_FORWARD/REVERSE/NEUTRAL strobes, counting period-start ticks from the servo, so multi-step moves run without per-period CPU writes. One instance per axis, placed between the APB bus and the tracking servo's command inputs.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..64
- CNT_W, 16, width of the period count per entry (fixed at 16 in the register map)
- PCLK  in  1  clock, 100 MHz
- PRESET  in  1  reset, synchronous, active-high
- PSEL, PENABLE, PWRITE  in  1 each  APB3 control
- PADDR  in  32  decoded on PADDR[3:0]
- PWDATA  in  32  write data
- PRDATA  out  32  read data, registered
- PREADY  out  1  tied 1
- PSLVERR  out  1  error, combinational, valid in the access phase
- period_tick  in  1  one-cycle pulse at each servo PWM period start
- cmd_forward, cmd_reverse, cmd_neutral  out  1 each  one-cycle strobes to the servo's SET_PW_* inputs
- busy  out  1  high while an entry is executing
- irq_done  out  1  one-cycle pulse when the queue drains naturally

## Operation
- Register map:
  - 0x0 PUSH (W): [17:16] dir (01 fwd, 10 rev, 00 neutral, 11 illegal), [15:0] periods.
  - 0x4 STATUS (R): [0] empty, [1] full, [2] busy, [3] paused, [4] overflow, [5] bad_cmd, [15:8] level.
  - 0x8 CTRL (W): [0] flush, [1] pause (level), [2] clear sticky flags.
  - 0xC REMAIN (R): periods left in the current entry.
  - Unmapped reads return 0xFFFFFFFF. Unmapped writes are ignored.
- Writes act only when PSEL & PWRITE & PENABLE.
- PUSH is rejected when the FIFO is full or dir==11. On reject: PSLVERR=1 in that access phase, overflow or bad_cmd flag set (sticky), FIFO unchanged. A full FIFO rejects the push even if a pop happens in the same cycle.
- FSM states: IDLE, RUN.
  - IDLE, FIFO non-empty, not paused: pop the head.
    - periods==0: entry discarded, no strobe, stay IDLE.
    - periods>0: remain<=periods, strobe for dir registered, go RUN, busy=1.
  - RUN, period_tick: remain decrements.
    - remain reaches 0, FIFO non-empty, not paused: pop the next entry as in IDLE in the same edge. Chained entries get no neutral strobe between them.
    - remain reaches 0 otherwise: cmd_neutral pulse; go IDLE. irq_done pulses only if the FIFO is empty.
- Pause is checked only at entry boundaries. It never truncates a running entry.
- Flush: FIFO emptied, remain<=0. If RUN: cmd_neutral pulse, go IDLE, no irq_done. Sticky flags are not affected.
- Simultaneous push and pop (FIFO not full): both happen, level unchanged.
- period_tick is ignored in IDLE. A tick in the pop cycle is not counted against the new entry.
- At most one of cmd_* is high in any cycle.

## Timing
- Reset values:
  - outputs: cmd_*, busy, irq_done, PSLVERR and PRDATA all 0.
  - internal: FIFO empty, state IDLE, pause 0, flags 0, remain 0.
- PRDATA is loaded on the edge where PSEL & !PWRITE & !PENABLE (setup phase). It is valid throughout the access phase.
- Pop latency:
  - A PUSH completing at edge N into an empty, idle, unpaused queue: pop at edge N+1; strobe and busy high after N+1.
  - Strobe width is exactly 1 cycle.
- Entry end: the tick sampled at edge T with remain==1 gives the next strobe (or cmd_neutral + irq_done) high after edge T, for 1 cycle.
- An entry of P periods spans exactly P period_tick pulses after its strobe.
- Reset mid-RUN: all state cleared on the next edge, no strobes issued.

## Test plan
- Push fwd/3, then drive ticks every 20 cycles. Expect: cmd_forward 1 cycle after the pop; cmd_neutral + irq_done after the 3rd tick; busy high across exactly 3 ticks.
- Push fwd/2, rev/1, neutral/1. Expect: strobes fwd, rev, neutral with no intervening neutral at the boundaries; final cmd_neutral + irq_done after tick 4.
- Fill to 8, push a 9th: PSLVERR=1, STATUS overflow=1, level=8. Push dir=11: PSLVERR=1, bad_cmd=1. CTRL[2] clears both flags.
- Push rev/0 then fwd/1. Expect: no cmd_reverse; cmd_forward 2 cycles after the pushes settle.
- Set pause mid-entry with rev/2, fwd/2 queued. Expect: rev completes, cmd_neutral, busy=0, level=1. Clear pause → cmd_forward.
- Flush during RUN with remain=5: cmd_neutral next cycle, level=0, REMAIN=0, no irq_done. Assert PRESET during RUN: all outputs 0 the next cycle.
